uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Next-generation UART receiver. Frame format is runtime-configurable: 5..MAX_DATA data bits, optional odd/even parity, 1 or 2 stop bits.
//  Each bit is decided by a 3-sample majority vote at bit centre. Break is detected.
//  Received frames and their error flags are buffered in a show-ahead FIFO with a valid/ready read side.
//  Sits between the shared baud-tick generator (rx_tick = OVERSAMPLE x baud) and the host/bus interface.
// PARAMETERS
//  MAX_DATA    9   widest data field supported (>=5)
//  OVERSAMPLE  16  rx_tick pulses per bit (>=8, even)
//  FIFO_DEPTH  8   frame entries buffered (power of 2, >=2)
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous, active-low reset
//  rx_tick        in   1   1-cycle oversample strobe
//  rx             in   1   serial line, asynchronous, idle high
//  data_bits      in   4   data field length; <5 treated as 5, >MAX_DATA treated as MAX_DATA
//  parity_en      in   1   parity bit present
//  parity_odd     in   1   1 = odd parity, 0 = even parity
//  two_stop       in   1   1 = two stop bits
//  rd_data        out  MAX_DATA  head entry data, right-aligned, unused MSBs = 0
//  rd_parity_err  out  1   head entry parity error
//  rd_framing_err out  1   head entry framing error
//  rd_break       out  1   head entry break
//  rd_valid       out  1   FIFO not empty
//  rd_ready       in   1   pop head when rd_valid & rd_ready
//  fifo_level     out  $clog2(FIFO_DEPTH+1)  entries held
//  overrun        out  1   sticky: a frame was dropped because the FIFO was full
//  clr_overrun    in   1   clears overrun; a same-cycle set wins
//  busy           out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset: every output is 0, FIFO empty, FSM in IDLE. Sync flops and the previous-sample flop reset to 1.
//  - rx passes through a 2-flop synchroniser. All FSM activity occurs only on cycles with rx_tick=1.
//  - States: IDLE, START, DATA, PARITY, STOP1, STOP2. Tick counter cnt.
//  - IDLE: falling edge (prev=1, now=0) -> START with cnt=0. A line held low never retriggers.
//  - START: samples at cnt = OS/2-3, OS/2-2, OS/2-1. Majority evaluated at OS/2-1.
//    Majority 1 -> false start, return to IDLE. Majority 0 -> DATA with cnt=0.
//    data_bits, parity_en, parity_odd and two_stop are latched at this point; mid-frame changes are ignored.
//  - DATA/PARITY/STOP*: samples at cnt = OS-3, OS-2, OS-1. Bit = majority, decided at cnt==OS-1, then cnt=0.
//  - Data is received LSB first. After the last data bit -> PARITY if parity_en, else STOP1.
//  - parity_err: even mode, XOR(data, parity bit) != 0; odd mode, XOR(data, parity bit) == 0. It is 0 when parity is disabled.
//  - STOP1 = 0 -> framing_err. If two_stop, STOP2 is also checked (framing_err if either is 0).
//  - break = all data bits 0 & parity bit 0 (if present) & STOP1 = 0; it implies framing_err. STOP2 is skipped on break.
//  - Frame completes at the decision of the final stop bit. The push occurs on that clk edge; rd_valid rises the next cycle at the earliest.
//    FSM returns to IDLE the same cycle.
//  - Push when full: accepted only if a pop occurs in the same cycle; otherwise the entry is dropped, overrun=1, and the FIFO is unchanged.
//  - Push and pop in the same cycle: fifo_level is unchanged. Pop when empty: ignored. Pointers wrap modulo FIFO_DEPTH.
//  - rd_* outputs are the FIFO head (show-ahead), combinational from storage, and hold stable while rd_valid & !rd_ready.
//  - Reset mid-frame: frame discarded, FIFO cleared, line re-armed (a falling edge is needed).
// STRUCTURE
//  - Package uart_pkg: state enum, MIN_DATA=5 constant, and a frame-entry struct/width constant {brk, ferr, perr, data}.
//  - Sub-module sync_fifo #(WIDTH, DEPTH): show-ahead, level output, full/empty, simultaneous push/pop.
//  - Top level holds the synchroniser, majority sampler, FSM, shift register and overrun flag.
// TESTING (OVERSAMPLE=16, 8N1 unless stated)
//  - Send 0xA5 -> one entry with rd_data=0x0A5 and all flags 0; rd_valid rises 1 clk after the stop-bit decision; busy falls.
//  - data_bits=7, even parity, 0x41 with parity bit 1 (wrong) -> rd_data=0x41, rd_parity_err=1, ferr=0.
//  - Start low for only 4 ticks -> no entry, busy back to 0. A 1-tick glitch at centre of a data bit -> data unaffected.
//  - Line low for 12 bit-times then high -> exactly one entry: data=0, ferr=1, brk=1. The next frame after line high is clean.
//  - FIFO_DEPTH=4, rd_ready=0, send 0x11..0x55 -> level=4, overrun=1, pops return 0x11,0x22,0x33,0x44. clr_overrun -> overrun=0.
//  - two_stop=1 with STOP2=0 -> ferr=1, brk=0. Assert rst mid-data-bit -> all outputs 0, the following 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_t : receiver FSM states
//   MIN_DATA   : narrowest data field accepted
//   rx_flags_t : per-frame error flags, stored above the data field
//   entry_w()  : FIFO entry width {brk, ferr, perr, data}
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } rx_state_t;

  localparam int MIN_DATA = 5;
  localparam int FLAG_W   = 3;

  typedef struct packed {
    logic brk;
    logic ferr;
    logic perr;
  } rx_flags_t;

  function automatic int entry_w(input int max_data);
    return max_data + FLAG_W;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, rst      : clock, asynchronous active-low reset
//   push, wr_data : write request and entry
//   pop           : remove head (ignored when empty)
//   rd_data       : head entry, zero while empty
//   full, empty   : occupancy flags
//   level         : number of entries held
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format and a show-ahead frame FIFO.
//   clk, rst        : clock, asynchronous active-low reset
//   rx_tick         : oversample strobe (OVERSAMPLE per bit)
//   rx              : asynchronous serial line, idle high
//   data_bits, parity_en, parity_odd, two_stop : frame format, latched at start
//   rd_data, rd_parity_err, rd_framing_err, rd_break : FIFO head entry
//   rd_valid, rd_ready : read handshake
//   fifo_level      : entries held
//   overrun         : sticky dropped-frame flag, cleared by clr_overrun
//   busy            : receiver is inside a frame
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int MAX_DATA   = 9,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_tick,
  input  logic                            rx,
  input  logic [3:0]                      data_bits,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            two_stop,
  output logic [MAX_DATA-1:0]             rd_data,
  output logic                            rd_parity_err,
  output logic                            rd_framing_err,
  output logic                            rd_break,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overrun,
  input  logic                            clr_overrun,
  output logic                            busy
);

  localparam int CNT_W   = $clog2(OVERSAMPLE);
  localparam int ENTRY_W = entry_w(MAX_DATA);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [3:0] clamp_bits(input logic [3:0] db);
    if (db < 4'(MIN_DATA))      return 4'(MIN_DATA);
    else if (db > 4'(MAX_DATA)) return 4'(MAX_DATA);
    else                        return db;
  endfunction

  rx_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic               rx_p0, rx_p1, rx_prev;
  logic [3:0]         nbits_q;
  logic [3:0]         bit_idx;
  logic               par_en_q, par_odd_q, two_stop_q;
  logic [1:0]         smp;
  logic [MAX_DATA-1:0] shreg;
  logic               pbit_q, perr_q;
  logic               ferr_q;

  logic [CNT_W-1:0]   pos_a, pos_b, pos_dec;
  logic               bit_val, decide, brk_now;
  logic               push;
  rx_flags_t          push_flags;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  rx_flags_t          head_flags;
  logic               fifo_full, fifo_empty, pop;

  // Start bit is sampled around its centre; all later bits at the end of
  // their tick window, which lands on bit centre because the start
  // decision already sits half a bit in.
  always_comb begin
    if (state == S_START) begin
      pos_a   = CNT_W'(OVERSAMPLE/2 - 3);
      pos_b   = CNT_W'(OVERSAMPLE/2 - 2);
      pos_dec = CNT_W'(OVERSAMPLE/2 - 1);
    end else begin
      pos_a   = CNT_W'(OVERSAMPLE - 3);
      pos_b   = CNT_W'(OVERSAMPLE - 2);
      pos_dec = CNT_W'(OVERSAMPLE - 1);
    end
  end

  assign bit_val = maj3(smp[0], smp[1], rx_p1);
  assign decide  = rx_tick && (state != S_IDLE) && (cnt == pos_dec);
  assign brk_now = (shreg == '0) && !pbit_q && !bit_val;

  // Frame completion: push on the final stop-bit decision.
  always_comb begin
    push            = 1'b0;
    push_flags.brk  = 1'b0;
    push_flags.ferr = 1'b0;
    push_flags.perr = perr_q;
    if (decide && state == S_STOP1) begin
      push_flags.brk  = brk_now;
      push_flags.ferr = !bit_val;
      push            = brk_now || !two_stop_q;
    end else if (decide && state == S_STOP2) begin
      push_flags.ferr = ferr_q || !bit_val;
      push            = 1'b1;
    end
  end

  assign push_entry = {push_flags, shreg};

  // Synchroniser, edge detect and frame FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      nbits_q    <= 4'(MIN_DATA);
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      if (rx_tick) begin
        rx_prev <= rx_p1;
        if (state != S_IDLE) cnt <= (cnt == pos_dec) ? '0 : cnt + 1'b1;
        case (state)
          S_IDLE: begin
            if (rx_prev && !rx_p1) begin
              state <= S_START;
              cnt   <= '0;
            end
          end
          S_START: begin
            if (decide) begin
              if (bit_val) begin
                state <= S_IDLE;
              end else begin
                state      <= S_DATA;
                bit_idx    <= '0;
                nbits_q    <= clamp_bits(data_bits);
                par_en_q   <= parity_en;
                par_odd_q  <= parity_odd;
                two_stop_q <= two_stop;
              end
            end
          end
          S_DATA: begin
            if (decide) begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == nbits_q - 4'd1) state <= par_en_q ? S_PARITY : S_STOP1;
            end
          end
          S_PARITY: if (decide) state <= S_STOP1;
          S_STOP1: begin
            if (decide) state <= (brk_now || !two_stop_q) ? S_IDLE : S_STOP2;
          end
          S_STOP2: if (decide) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Sample capture and frame assembly
  always_ff @(posedge clk) begin
    if (rx_tick && state != S_IDLE) begin
      if (cnt == pos_a) smp[0] <= rx_p1;
      if (cnt == pos_b) smp[1] <= rx_p1;
      if (decide) begin
        case (state)
          S_START: begin
            shreg  <= '0;
            pbit_q <= 1'b0;
            perr_q <= 1'b0;
          end
          S_DATA:   shreg <= shreg | (MAX_DATA'(bit_val) << bit_idx);
          S_PARITY: begin
            pbit_q <= bit_val;
            perr_q <= (^shreg) ^ bit_val ^ par_odd_q;
          end
          S_STOP1:  ferr_q <= !bit_val;
          default:  ;
        endcase
      end
    end
  end

  // Overrun: a same-cycle drop wins over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign pop = rd_valid && rd_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign head_flags     = head[ENTRY_W-1 -: FLAG_W];
  assign rd_data        = head[MAX_DATA-1:0];
  assign rd_break       = head_flags.brk;
  assign rd_framing_err = head_flags.ferr;
  assign rd_parity_err  = head_flags.perr;
  assign rd_valid       = !fifo_empty;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (OVERSAMPLE=16, FIFO_DEPTH=4).
// Entries are packed {brk, ferr, perr, data[8:0]}.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] data_bits = 4'd8;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic [8:0] rd_data;
  logic       rd_parity_err, rd_framing_err, rd_break, rd_valid;
  logic       rd_ready = 1'b1;
  logic [2:0] fifo_level;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       busy;

  int vectors = 0;
  int errors  = 0;
  logic [11:0] sb[$];

  uart_rx_fifo #(.MAX_DATA(9), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx(rx),
    .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
    .two_stop(two_stop), .rd_data(rd_data), .rd_parity_err(rd_parity_err),
    .rd_framing_err(rd_framing_err), .rd_break(rd_break), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .fifo_level(fifo_level), .overrun(overrun),
    .clr_overrun(clr_overrun), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #2;
    rx_tick = ~rx_tick;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every popped head against the scoreboard
  always @(negedge clk) begin
    if (rst && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_entry", int'({rd_break, rd_framing_err, rd_parity_err, rd_data}), 0);
      end else begin
        check("entry", int'({rd_break, rd_framing_err, rd_parity_err, rd_data}), int'(sb.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic ticks(input int n);
    cyc(2 * n);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    rx = b;
    if (glitch) begin
      ticks(7); rx = ~b; ticks(1); rx = b; ticks(8);
    end else begin
      ticks(16);
    end
  endtask

  // pbit/s1/s2 < 0 omit that bit; gl = data bit index to glitch or -1
  task automatic send_frame(input logic [8:0] d, input int nb, input int pbit,
                            input int s1, input int s2, input int gl);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i], (i == gl));
    if (pbit >= 0) send_bit(pbit[0], 1'b0);
    if (s1 >= 0) begin
      send_bit(s1[0], 1'b0);
      if (s2 >= 0) send_bit(s2[0], 1'b0);
      send_bit(1'b1, 1'b0);
    end
  endtask

  initial begin
    cyc(4);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    ticks(20);

    // 0xA5, 8N1, timing of rd_valid around the stop decision
    rd_ready = 1'b0;
    sb.push_back(12'h0A5);
    send_frame(9'h0A5, 8, -1, -1, -1, -1);
    rx = 1'b1;
    ticks(4);
    check("valid_early", rd_valid, 0);
    check("busy_in_stop", busy, 1);
    ticks(9);
    check("valid_after_stop", rd_valid, 1);
    check("busy_after_stop", busy, 0);
    check("level_one", fifo_level, 1);
    rd_ready = 1'b1;
    ticks(16);

    // 7E1, 0x41 with wrong parity bit
    data_bits = 4'd7; parity_en = 1'b1; parity_odd = 1'b0;
    sb.push_back({3'b001, 9'h041});
    send_frame(9'h041, 7, 1, 1, -1, -1);

    // 9 data bits, odd parity, correct parity bit
    data_bits = 4'd9; parity_odd = 1'b1;
    sb.push_back(12'h1A5);
    send_frame(9'h1A5, 9, 0, 1, -1, -1);

    // data_bits below minimum acts as 5
    data_bits = 4'd3; parity_en = 1'b0; parity_odd = 1'b0;
    sb.push_back(12'h015);
    send_frame(9'h015, 5, -1, 1, -1, -1);
    data_bits = 4'd8;

    // short start pulse
    rx = 1'b0; ticks(4); rx = 1'b1; ticks(24);
    check("false_start_busy", busy, 0);
    check("false_start_level", fifo_level, 0);

    // 1-tick glitch in centre of data bit 3
    sb.push_back(12'h05A);
    send_frame(9'h05A, 8, -1, 1, -1, 3);

    // break, then a clean frame
    sb.push_back({3'b110, 9'h000});
    rx = 1'b0; ticks(12 * 16); rx = 1'b1; ticks(32);
    check("break_busy", busy, 0);
    sb.push_back(12'h096);
    send_frame(9'h096, 8, -1, 1, -1, -1);

    // overrun with depth 4
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back({3'b000, 1'b0, 8'(i * 8'h11)});
      send_frame({1'b0, 8'(i * 8'h11)}, 8, -1, 1, -1, -1);
    end
    check("ovr_level", fifo_level, 4);
    check("ovr_flag", overrun, 1);
    check("ovr_head", rd_data, 9'h011);
    clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0; cyc(1);
    check("ovr_cleared", overrun, 0);
    rd_ready = 1'b1;
    cyc(10);
    check("drain_level", fifo_level, 0);

    // two stop bits
    two_stop = 1'b1;
    sb.push_back({3'b010, 9'h033});
    send_frame(9'h033, 8, -1, 1, 0, -1);
    sb.push_back(12'h00F);
    send_frame(9'h00F, 8, -1, 1, 1, -1);
    two_stop = 1'b0;

    // reset mid-frame with an entry held
    rd_ready = 1'b0;
    send_frame(9'h077, 8, -1, 1, -1, -1);
    check("pre_rst_level", fifo_level, 1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    ticks(8);
    rst = 1'b0;
    cyc(3);
    check("midrst_busy", busy, 0);
    check("midrst_valid", rd_valid, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_data", rd_data, 0);
    check("midrst_overrun", overrun, 0);
    rst = 1'b1;
    rx = 1'b1;
    ticks(32);
    rd_ready = 1'b1;
    sb.push_back(12'h03C);
    send_frame(9'h03C, 8, -1, 1, -1, -1);

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 2000) begin cyc(1); guard++; end
      check("scoreboard_drained", sb.size(), 0);
    end
    check("final_level", fifo_level, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
